// File: rtl/row_sel_encoder_pkg.sv
// Shared types and helpers for the row-select encoder.
// Optional onehot checking is enabled by defining ROW_SEL_ENCODER_ONEHOT_CHK_EN.
package row_sel_encoder_pkg;

  localparam int N_ROWS_DEFAULT = 8;
  // Widest request vector the lowest-set-bit helper handles.
  localparam int MAX_ROWS = 32;
  localparam int MAX_AW   = 5;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_t;

  // Index of the lowest set bit; 0 when no bit is set.
  function automatic logic [MAX_AW-1:0] lsb_index(input logic [MAX_ROWS-1:0] vec);
    logic [MAX_AW-1:0] idx;
    idx = '0;
    for (int i = MAX_ROWS - 1; i >= 0; i--) begin
      if (vec[i]) idx = MAX_AW'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/row_sel_encoder_prio_enc_lsb.sv
// Combinational LSB-first priority encoder: index of lowest set bit plus any-bit flag.
// Supports N_ROWS up to row_sel_encoder_pkg::MAX_ROWS.
module prio_enc_lsb
  import row_sel_encoder_pkg::*;
#(
  parameter int N_ROWS = N_ROWS_DEFAULT,
  localparam int AW = $clog2(N_ROWS)
) (
  input  logic [N_ROWS-1:0] vec,
  output logic [AW-1:0]     index,
  output logic              any
);

  logic [MAX_ROWS-1:0] vec_ext;

  assign vec_ext = MAX_ROWS'(vec);
  assign index   = AW'(lsb_index(vec_ext));
  assign any     = |vec;

endmodule

// File: rtl/row_sel_encoder.sv
// Serialises a captured row request vector into ascending binary row addresses
// over a valid/ready handshake. Define ROW_SEL_ENCODER_ONEHOT_CHK_EN to add onehot_err.
module row_sel_encoder
  import row_sel_encoder_pkg::*;
#(
  parameter int N_ROWS = N_ROWS_DEFAULT,
  localparam int AW = $clog2(N_ROWS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              nen,
  input  logic              load,
  input  logic [N_ROWS-1:0] req,
  output logic [AW-1:0]     addr,
  output logic              addr_valid,
  input  logic              addr_ready,
  output logic              busy,
  output logic              done
`ifdef ROW_SEL_ENCODER_ONEHOT_CHK_EN
  ,
  output logic              onehot_err
`endif
);

  state_t            state_reg, state_next;
  logic [N_ROWS-1:0] pending_reg, pending_next, pending_cleared;
  logic              done_reg, done_next;
  logic [AW-1:0]     lsb_idx;
  logic              lsb_any;
  logic              in_emit;

  prio_enc_lsb #(.N_ROWS(N_ROWS)) u_prio (
    .vec   (pending_reg),
    .index (lsb_idx),
    .any   (lsb_any)
  );

  assign in_emit         = (state_reg == EMIT);
  assign pending_cleared = pending_reg & ~(N_ROWS'(1) << lsb_idx);
  assign addr_valid      = in_emit & lsb_any;
  assign addr            = addr_valid ? lsb_idx : '0;
  assign busy            = in_emit;
  assign done            = done_reg;

  always_comb begin
    state_next   = state_reg;
    pending_next = pending_reg;
    done_next    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (load && !nen && (req != '0)) begin
          pending_next = req;
          state_next   = EMIT;
        end
      end
      EMIT: begin
        // Abort takes priority over a transfer in the same cycle.
        if (nen) begin
          pending_next = '0;
          state_next   = IDLE;
        end else if (addr_valid && addr_ready) begin
          pending_next = pending_cleared;
          if (pending_cleared == '0) begin
            state_next = IDLE;
            done_next  = 1'b1;
          end
        end
      end
      default: begin
        pending_next = '0;
        state_next   = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      pending_reg <= '0;
      done_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      pending_reg <= pending_next;
      done_reg    <= done_next;
    end
  end

`ifdef ROW_SEL_ENCODER_ONEHOT_CHK_EN
  logic capture;
  logic onehot_err_reg;

  // Any accepted load, including an all-zero one, refreshes the flag.
  assign capture = (state_reg == IDLE) & load & ~nen;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      onehot_err_reg <= 1'b0;
    end else if (capture) begin
      onehot_err_reg <= !((req != '0) && ((req & (req - N_ROWS'(1))) == '0));
    end
  end

  assign onehot_err = onehot_err_reg;
`endif

endmodule

// File: doc/row_sel_encoder.md
Name: row_sel_encoder

Overview:
- Inverse of the row-select decoder: captures an N-bit row request vector and serialises it into a stream of binary row addresses, one per set bit, in ascending order.
- Uses a valid/ready handshake toward the downstream consumer. That consumer typically drives the decoder's addr input.
- Sits between keypad/row-scan logic and the addressed-row datapath.
- Active-low enable matches the decoder's nen convention.

Parameters:
- N_ROWS, 8, number of request lines; must be a power of 2, ≥2.
- AW, $clog2(N_ROWS), address width (derived; not to be overridden).

Ports:
- clk  in  1  single system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- nen  in  1  active-low enable; 1 = block disabled/aborted.
- load  in  1  capture strobe for req (sampled on clk).
- req  in  N_ROWS  row request vector, bit i = row i.
- addr  out  AW  binary address of the current row being offered.
- addr_valid  out  1  addr is valid this cycle.
- addr_ready  in  1  consumer accepts addr this cycle.
- busy  out  1  vector captured and not yet fully emitted.
- done  out  1  one-cycle pulse after the last address is accepted.

Behaviour:
- Reset (rst_n=0, async): state IDLE, pending=0, addr=0, addr_valid=0, busy=0, done=0.
- States: IDLE, EMIT (enum in package).
- IDLE:
  - load=1 & nen=0 & req≠0 → capture pending=req, go to EMIT next cycle.
  - load with req=0 → stays IDLE, no done pulse.
  - load while nen=1 → ignored.
- EMIT:
  - addr_valid=1, busy=1.
  - addr = index of lowest set bit of pending (combinational from the registered pending).
  - Transfer occurs on clk when addr_valid & addr_ready.
  - On transfer, clear that bit in pending.
  - If pending becomes 0 → IDLE, done=1 for exactly the next cycle.
  - Otherwise stay in EMIT, addr updates to the next set bit the following cycle.
  - With continuous ready: one address per cycle. Latency from load to first addr_valid = 1 cycle.
- Handshake rules:
  - addr/addr_valid are stable while addr_valid=1 & addr_ready=0.
  - load in EMIT is ignored; no re-capture until IDLE.
- Abort: nen=1 in EMIT → next cycle IDLE, pending=0, addr_valid=0, no done pulse.
- Simultaneous events:
  - Last transfer and nen=1 in the same cycle → abort wins, done not pulsed.
  - done pulse and a new load in the same cycle → load is accepted, because the state is already IDLE.
- addr outputs 0 whenever addr_valid=0.
- Boundaries:
  - req=all-ones → N_ROWS addresses 0..N_ROWS-1.
  - Single-bit req → one address, then done.

Optional Feature:
- Macro: ROW_SEL_ENCODER_ONEHOT_CHK_EN.
- When defined, adds output onehot_err (1 bit):
  - Registered on an accepted capture: 1 if the captured req is not exactly one-hot (zero or multiple bits).
  - A zero-vector load also updates it to 1.
  - Sticky until the next accepted load; reset 0.
- When undefined, the port and logic are absent. Core behaviour is identical either way.

Decomposition:
- Package row_sel_encoder_pkg: state_t enum {IDLE, EMIT}, default N_ROWS constant, helper function for lowest-set-bit index.
- Sub-module prio_enc_lsb (purely combinational): N_ROWS in, AW index out plus any-bit flag. Instantiated once on pending.

Test Plan:
- Reset mid-EMIT with req=8'b1010_0000 loaded → all outputs 0 immediately (async), state IDLE.
- load req=8'b1001_0010, ready=1 → addr 1,4,7 on consecutive cycles, then done pulse 1 cycle; busy falls with done.
- req=8'b0000_1100, ready low 3 cycles at first offer → addr=2 held stable with valid=1, then 2,3 emitted, done.
- nen=1 after first transfer of req=8'b1111_1111 → valid drops next cycle, no done; a subsequent load with nen=0 restarts from addr 0.
- load req=0 → no valid, no done, busy=0; with ROW_SEL_ENCODER_ONEHOT_CHK_EN, onehot_err=1. Load 8'b0001_0000 → onehot_err=0, addr=4.
- load asserted during EMIT with a different req → ignored; original sequence completes unchanged.
